// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: circular byte FIFO in front of the UART transmitter.
// Host writes with wr_en/wr_data; a 4-state FSM drains one entry per frame.
//
// Ports:
//   clk, resetn          system clock, async active-low reset
//   wr_en, wr_data       host write strobe and data
//   full, empty, count   occupancy status, decoded from count
//   wr_drop              registered pulse after a write attempted while full
//   uart_tx_en           one-cycle send strobe to the transmitter
//   uart_tx_data         registered byte presented to the transmitter
//   uart_tx_busy         transmitter busy flag
module uart_tx_fifo #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    wr_en,
    input  logic [PAYLOAD_BITS-1:0] wr_data,
    output logic                    full,
    output logic                    empty,
    output logic [DEPTH_LOG2:0]     count,
    output logic                    wr_drop,
    output logic                    uart_tx_en,
    output logic [PAYLOAD_BITS-1:0] uart_tx_data,
    input  logic                    uart_tx_busy
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2 + 1)'(1);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    logic [PAYLOAD_BITS-1:0] mem [DEPTH];

    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [DEPTH_LOG2:0]     cnt_q;
    logic                    drop_q;
    logic [PAYLOAD_BITS-1:0] tx_data_q;

    state_t state_q;
    state_t state_d;

    logic push;
    logic pop;

    // Flags come from the counter only, so they reflect the state
    // before the current edge.
    assign full  = (cnt_q == CNT_FULL);
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    assign push = wr_en && !full;

    assign wr_drop      = drop_q;
    assign uart_tx_data = tx_data_q;

    // Pure state decode: async reset clears state, so en drops at once.
    assign uart_tx_en = (state_q == S_ISSUE);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!empty && !uart_tx_busy) begin
                    pop     = 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                // The transmitter raises busy one cycle after en.
                if (uart_tx_busy) begin
                    state_d = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Storage has no reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
        end else if (push) begin
            wr_ptr <= wr_ptr + PTR_ONE;
        end
    end

    // Pop reads the old head even when a push lands on the same edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr    <= '0;
            tx_data_q <= '0;
        end else if (pop) begin
            rd_ptr    <= rd_ptr + PTR_ONE;
            tx_data_q <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CNT_ONE;
                2'b01:   cnt_q <= cnt_q - CNT_ONE;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= wr_en && full;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo with a simple
// transmitter model that holds busy for FRAME cycles per byte.
module tb_uart_tx_fifo;

    localparam int FRAME = 8;

    logic       clk;
    logic       resetn;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       wr_drop;
    logic       uart_tx_en;
    logic [7:0] uart_tx_data;
    logic       uart_tx_busy;

    logic       busy_m;
    logic       hold_busy;
    int         frame_cnt;

    int         n_vec;
    int         n_err;
    int         n_tx;
    logic       prev_en;
    logic [7:0] exp_q [$];

    uart_tx_fifo dut (
        .clk          (clk),
        .resetn       (resetn),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .full         (full),
        .empty        (empty),
        .count        (count),
        .wr_drop      (wr_drop),
        .uart_tx_en   (uart_tx_en),
        .uart_tx_data (uart_tx_data),
        .uart_tx_busy (uart_tx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign uart_tx_busy = busy_m | hold_busy;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_m    <= 1'b0;
            frame_cnt <= 0;
        end else if (busy_m) begin
            if (frame_cnt == 0) begin
                busy_m <= 1'b0;
            end else begin
                frame_cnt <= frame_cnt - 1;
            end
        end else if (uart_tx_en) begin
            busy_m    <= 1'b1;
            frame_cnt <= FRAME - 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            prev_en = 1'b0;
        end else begin
            if (uart_tx_en) begin
                n_tx++;
                chk("en_single", 32'(prev_en), 32'd0);
                chk("en_while_busy", 32'(busy_m), 32'd0);
                if (exp_q.size() == 0) begin
                    chk("tx_unexp", 32'(exp_q.size()), 32'd1);
                end else begin
                    chk("tx_data", 32'(uart_tx_data), 32'(exp_q.pop_front()));
                end
            end
            prev_en = uart_tx_en;
        end
    end

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || busy_m || !empty) && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("drain_timeout", 32'(cyc >= 2000), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        int nxt;
        int cyc;

        n_vec     = 0;
        n_err     = 0;
        n_tx      = 0;
        prev_en   = 1'b0;
        resetn    = 1'b0;
        wr_en     = 1'b0;
        wr_data   = '0;
        hold_busy = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_drop", 32'(wr_drop), 32'd0);
        chk("rst_en", 32'(uart_tx_en), 32'd0);
        chk("rst_data", 32'(uart_tx_data), 32'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // single byte latency
        wr_en   = 1'b1;
        wr_data = 8'hA5;
        exp_q.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        chk("lat_cnt1", 32'(count), 32'd1);
        chk("lat_empty0", 32'(empty), 32'd0);
        chk("lat_en0", 32'(uart_tx_en), 32'd0);
        @(negedge clk);
        chk("lat_en1", 32'(uart_tx_en), 32'd1);
        chk("lat_data", 32'(uart_tx_data), 32'hA5);
        chk("lat_cnt0", 32'(count), 32'd0);
        chk("lat_empty1", 32'(empty), 32'd1);
        wait_drain();

        // burst 0x00..0x0F behind a live transmitter
        base = n_tx;
        for (int i = 0; i < 16; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(i);
            exp_q.push_back(8'(i));
            @(negedge clk);
            chk("burst_drop", 32'(wr_drop), 32'd0);
        end
        wr_en = 1'b0;
        wait_drain();
        chk("burst_ntx", 32'(n_tx - base), 32'd16);

        // overflow with busy held high
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 17; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h40 + i);
            if (i < 16) exp_q.push_back(8'(8'h40 + i));
            @(negedge clk);
            chk("ovf_cnt", 32'(count), 32'((i < 16) ? i + 1 : 16));
            chk("ovf_full", 32'(full), 32'(i >= 15));
            chk("ovf_drop", 32'(wr_drop), 32'(i == 16));
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("ovf_drop_off", 32'(wr_drop), 32'd0);
        chk("ovf_cnt_hold", 32'(count), 32'd16);

        // push and pop on the same edge while full
        base      = n_tx;
        hold_busy = 1'b0;
        wr_en     = 1'b1;
        wr_data   = 8'h77;
        @(negedge clk);
        wr_en = 1'b0;
        chk("fpp_drop", 32'(wr_drop), 32'd1);
        chk("fpp_cnt", 32'(count), 32'd15);
        chk("fpp_full", 32'(full), 32'd0);
        wait_drain();
        chk("fpp_ntx", 32'(n_tx - base), 32'd16);

        // push and pop on the same edge at count 3
        hold_busy = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h60 + i);
            exp_q.push_back(8'(8'h60 + i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("pp3_cnt_pre", 32'(count), 32'd3);
        hold_busy = 1'b0;
        wr_en     = 1'b1;
        wr_data   = 8'h63;
        exp_q.push_back(8'h63);
        @(negedge clk);
        wr_en = 1'b0;
        chk("pp3_cnt", 32'(count), 32'd3);
        chk("pp3_head", 32'(uart_tx_data), 32'h60);
        wait_drain();

        // wrap with random gaps
        base = n_tx;
        nxt  = 0;
        cyc  = 0;
        while (nxt < 40 && cyc < 5000) begin
            if ($urandom_range(0, 2) != 0 && (nxt - (n_tx - base)) < 14) begin
                wr_en   = 1'b1;
                wr_data = 8'(nxt);
                exp_q.push_back(8'(nxt));
                nxt++;
            end else begin
                wr_en = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        wr_en = 1'b0;
        chk("wrap_written", 32'(nxt), 32'd40);
        wait_drain();
        chk("wrap_sent", 32'(n_tx - base), 32'd40);

        // reset while in WAIT_DONE with 5 queued
        for (int i = 0; i < 6; i++) begin
            wr_en   = 1'b1;
            wr_data = 8'(8'h80 + i);
            exp_q.push_back(8'(8'h80 + i));
            @(negedge clk);
        end
        wr_en = 1'b0;
        @(negedge clk);
        chk("wd_cnt", 32'(count), 32'd5);
        resetn = 1'b0;
        #1;
        chk("wd_rst_en", 32'(uart_tx_en), 32'd0);
        chk("wd_rst_cnt", 32'(count), 32'd0);
        chk("wd_rst_empty", 32'(empty), 32'd1);
        chk("wd_rst_data", 32'(uart_tx_data), 32'd0);
        exp_q.delete();
        @(negedge clk);
        resetn = 1'b1;
        base   = n_tx;
        repeat (20) @(negedge clk);
        chk("post_rst_quiet", 32'(n_tx - base), 32'd0);
        chk("post_rst_cnt", 32'(count), 32'd0);
        wr_en   = 1'b1;
        wr_data = 8'h99;
        exp_q.push_back(8'h99);
        @(negedge clk);
        wr_en = 1'b0;
        wait_drain();
        chk("post_rst_ntx", 32'(n_tx - base), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
